// File: rtl/pipe_pkg.sv
// Shared definitions for the front-end pipeline registers: instruction types,
// field widths and the values that make up an ID/EX bubble.
package pipe_pkg;

  localparam int REG_W   = 5;
  localparam int INSTR_W = 32;
  localparam int TYPE_W  = 3;
  localparam int CNT_W   = 16;

  typedef enum logic [TYPE_W-1:0] {
    RR_ALU    = 3'd0,
    ALU_IMM   = 3'd1,
    LOAD      = 3'd2,
    STORE     = 3'd3,
    BRANCH    = 3'd4,
    PP_MOVE   = 3'd5,
    PP_HMOVE  = 3'd6,
    PP_VMOVE  = 3'd7
  } instr_type_e;

  // Register 0 is hardwired zero, so a bubble never forwards or interlocks.
  localparam instr_type_e      BUBBLE_TYPE = RR_ALU;
  localparam logic [REG_W-1:0] BUBBLE_REG  = '0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with load enable and a synchronous clear that
// takes priority over the enable.
module pipe_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)     q <= CLR_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers driven by the stall unit and EX branch
// resolution, plus saturating stall/flush counters for performance debug.
module pipe_front_regs
  import pipe_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              DATA_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enPC,
  input  logic                enIfId,
  input  logic                rstIdEx,
  input  logic                branchTaken,
  input  logic [PC_W-1:0]     branchTarget,
  input  logic [INSTR_W-1:0]  instrIn,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     ifIdPc,
  output logic [INSTR_W-1:0]  ifIdInstr,
  output logic                ifIdValid,
  input  logic [TYPE_W-1:0]   decInstrType,
  input  logic [REG_W-1:0]    decRS,
  input  logic [REG_W-1:0]    decRT,
  input  logic [REG_W-1:0]    decRegDest,
  input  logic [DATA_W-1:0]   decOpA,
  input  logic [DATA_W-1:0]   decOpB,
  output logic [TYPE_W-1:0]   exInstrType,
  output logic [REG_W-1:0]    exRS,
  output logic [REG_W-1:0]    exRT,
  output logic [REG_W-1:0]    exRegDest,
  output logic [DATA_W-1:0]   exOpA,
  output logic [DATA_W-1:0]   exOpB,
  output logic                exValid,
  output logic [CNT_W-1:0]    stallCount,
  output logic [CNT_W-1:0]    flushCount
);

  localparam int IFID_W = PC_W + INSTR_W + 1;
  localparam int IDEX_W = TYPE_W + 3 * REG_W + 2 * DATA_W + 1;
  localparam logic [IDEX_W-1:0] IDEX_BUBBLE =
    {TYPE_W'(BUBBLE_TYPE), BUBBLE_REG, BUBBLE_REG, BUBBLE_REG,
     {(2 * DATA_W){1'b0}}, 1'b0};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [PC_W-1:0]   pc_d;
  logic [IFID_W-1:0] ifid_q;
  logic [IDEX_W-1:0] idex_d, idex_q;

  // PC stage: a taken branch redirects even when the stall unit froze the PC.
  assign pc_d = branchTaken ? branchTarget : pc + PC_W'(4);

  pipe_reg #(.W(PC_W), .CLR_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .clr (rst),
    .en  (branchTaken | enPC),
    .d   (pc_d),
    .q   (pc)
  );

  // IF/ID stage
  pipe_reg #(.W(IFID_W)) u_ifid (
    .clk (clk),
    .clr (rst | branchTaken),
    .en  (enIfId),
    .d   ({pc, instrIn, 1'b1}),
    .q   (ifid_q)
  );
  assign {ifIdPc, ifIdInstr, ifIdValid} = ifid_q;

  // ID/EX stage: loads or bubbles every cycle, never holds.
  assign idex_d = {decInstrType, decRS, decRT, decRegDest, decOpA, decOpB, ifIdValid};

  pipe_reg #(.W(IDEX_W), .CLR_VAL(IDEX_BUBBLE)) u_idex (
    .clk (clk),
    .clr (rst | branchTaken | rstIdEx),
    .en  (1'b1),
    .d   (idex_d),
    .q   (idex_q)
  );
  assign {exInstrType, exRS, exRT, exRegDest, exOpA, exOpB, exValid} = idex_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else if (branchTaken) begin
      flushCount <= sat_inc(flushCount);
    end else if (!enPC) begin
      stallCount <= sat_inc(stallCount);
    end
  end

endmodule
